// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer memory.
//   - Default bus widths used by the completer and its storage.
//   - One-hot FSM state encoding (IDLE / WAIT / RESP).
//   - apb_resp_t: the response bundle presented back to the bus.
//   - addr_in_range(): decodes whether a local offset hits storage.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 8;
  localparam int APB_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_RESP = 3'b100
  } apb_state_e;

  typedef struct packed {
    logic                      ready;
    logic                      slverr;
    logic [APB_DATA_WIDTH-1:0] rdata;
  } apb_resp_t;

  // Offsets at or beyond depth are not backed by storage.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// Byte-wide storage for the APB completer.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset (clears the read register only)
//   we     - write enable (already qualified by the completer FSM)
//   waddr  - write address, wdata - write data
//   re     - load the read register from storage at raddr
//   clr    - force the read register to zero (error responses)
//   raddr  - read address
//   rdata  - registered read data; holds its value when re/clr are low
// Storage contents are deliberately not reset.
module apb_slave_mem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int AW         = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  clr,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  // clr wins over re so an errored access always returns zero.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register file, with a fixed number of
// wait states, PSLVERR on out-of-range offsets and a sticky protocol-error flag.
// Ports:
//   PCLK, PRESET        - clock and synchronous active-high reset
//   PSEL, PENABLE       - APB select / access-phase strobe from the master
//   PWRITE, PADDR, PWDATA - transfer direction, local byte offset, write data
//   PRDATA              - read data, valid with PREADY=1 on reads
//   PREADY, PSLVERR     - completion and error response (registered)
//   proto_err           - sticky: master broke APB sequencing; cleared by PRESET
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1); it completes on the rising edge where
// PSEL, PENABLE and PREADY are all high. Address, direction and write data
// are captured in the setup cycle and used for the whole transfer.
// FSM state is visible as state_q (one-hot apb_state_e).
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err
);

  localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  slverr_q, slverr_d;
  logic                  proto_q, proto_d;

  logic                  setup_ph, access_ph;
  logic                  mem_we, mem_re, mem_clr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  apb_resp_t             resp;

  assign setup_ph  = PSEL && !PENABLE;
  assign access_ph = PSEL && PENABLE;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      proto_q  <= proto_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    proto_d = proto_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup_ph) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = !addr_in_range(32'(PADDR), DEPTH);
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end else if (access_ph) begin
          // Access phase with no preceding setup phase.
          proto_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!access_ph) begin
          proto_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Bus must hold the transfer steady; latched copies stay in use.
          if (PADDR != addr_q || PWRITE != write_q || PWDATA != wdata_q) begin
            proto_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_RESP: begin
        // Either the completion edge or an aborted transfer; both end here.
        if (!access_ph) begin
          proto_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: the response registers load as the FSM enters RESP, so
  // PREADY/PSLVERR/PRDATA are valid for exactly the one RESP cycle.
  always_comb begin
    ready_d  = (state_d == S_RESP);
    slverr_d = (state_d == S_RESP) && err_d;
    mem_re   = (state_d == S_RESP) && !write_d && !err_d;
    mem_clr  = (state_d == S_RESP) && err_d;
    mem_we   = (state_q == S_RESP) && access_ph && write_q && !err_q && !PRESET;
  end

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (MEM_AW)
  ) u_array (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (mem_we),
    .waddr (addr_q[MEM_AW-1:0]),
    .wdata (wdata_q),
    .re    (mem_re),
    .clr   (mem_clr),
    .raddr (addr_d[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  assign resp      = '{ready: ready_q, slverr: slverr_q, rdata: mem_rdata};
  assign PREADY    = resp.ready;
  assign PSLVERR   = resp.slverr;
  assign PRDATA    = resp.rdata;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances share one APB bus with separate
// selects -- dut_a with two wait states, dut_b with zero wait states.
module tb_apb_slave_mem;

  localparam int DEPTH = 128;

  // Clock / reset
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic       psel_a, psel_b, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b, proto_a, proto_b;

  apb_slave_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .proto_err(proto_a)
  );

  apb_slave_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .proto_err(proto_b)
  );

  // Reference model: storage per instance, plus what the bus should show.
  logic [7:0] ref_mem   [2][DEPTH];
  bit         ref_valid [2][DEPTH];
  logic [7:0] ref_prdata [2];
  bit         ref_prdata_known [2];
  bit         ref_proto [2];

  int total = 0;
  int bad   = 0;

  function automatic int wait_of(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_psel(input int w, input logic v);
    if (w == 0) psel_a = v;
    else        psel_b = v;
  endtask

  task automatic sample(input int w, output logic [7:0] rd, output logic rdy,
                        output logic se, output logic pe);
    if (w == 0) begin rd = prdata_a; rdy = pready_a; se = pslverr_a; pe = proto_a; end
    else        begin rd = prdata_b; rdy = pready_b; se = pslverr_b; pe = proto_b; end
  endtask

  // Driver: one complete transfer, starting at a negedge. Leaves the bus
  // idle-ready at a negedge so a following call is back-to-back.
  task automatic xfer(input int w, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input string tag);
    logic [7:0] rd, exp_rd;
    logic       rdy, se, pe;
    bit         err, exp_known;
    int         n;
    set_psel(w, 1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    n = 1;
    sample(w, rd, rdy, se, pe);
    while (!rdy && n < 40) begin
      @(negedge pclk);
      n++;
      sample(w, rd, rdy, se, pe);
    end
    check({tag, " ready"}, 32'(rdy), 32'd1);
    check({tag, " access_cycles"}, 32'(n), 32'(wait_of(w) + 1));
    err = (int'(addr) >= DEPTH);
    check({tag, " slverr"}, 32'(se), 32'(err));
    if (err) begin
      exp_rd = 8'h00; exp_known = 1'b1;
    end else if (wr) begin
      exp_rd = ref_prdata[w]; exp_known = ref_prdata_known[w];
    end else begin
      exp_rd = ref_mem[w][addr[6:0]]; exp_known = ref_valid[w][addr[6:0]];
    end
    if (exp_known) check({tag, " prdata"}, 32'(rd), 32'(exp_rd));
    ref_prdata[w]       = exp_rd;
    ref_prdata_known[w] = exp_known;
    if (wr && !err) begin
      ref_mem[w][addr[6:0]]   = data;
      ref_valid[w][addr[6:0]] = 1'b1;
    end
    @(negedge pclk);
    sample(w, rd, rdy, se, pe);
    check({tag, " ready_after"}, 32'(rdy), 32'd0);
    check({tag, " slverr_after"}, 32'(se), 32'd0);
    check({tag, " proto"}, 32'(pe), 32'(ref_proto[w]));
    set_psel(w, 1'b0); penable = 1'b0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      ref_proto[w]        = 1'b0;
      ref_prdata[w]       = 8'h00;
      ref_prdata_known[w] = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " a_ready"},  32'(pready_a),  32'd0);
    check({tag, " a_slverr"}, 32'(pslverr_a), 32'd0);
    check({tag, " a_prdata"}, 32'(prdata_a),  32'd0);
    check({tag, " a_proto"},  32'(proto_a),   32'd0);
    check({tag, " a_state"},  32'(dut_a.state_q), 32'h1);
    check({tag, " b_ready"},  32'(pready_b),  32'd0);
    check({tag, " b_prdata"}, 32'(prdata_b),  32'd0);
    check({tag, " b_proto"},  32'(proto_b),   32'd0);
  endtask

  task automatic do_reset(input string tag);
    preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    model_reset();
    check_idle_outputs(tag);
    preset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    int         w;
    bit         wr;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) ref_valid[i][j] = 1'b0;
    pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    do_reset("reset");

    // Two wait states: write then read back.
    xfer(0, 1'b1, 8'h05, 8'hA5, "w2_wr05");
    xfer(0, 1'b0, 8'h05, 8'h00, "w2_rd05");

    // Zero wait states, back-to-back.
    xfer(1, 1'b1, 8'h10, 8'h11, "w0_wr10");
    xfer(1, 1'b1, 8'h11, 8'h22, "w0_wr11");
    xfer(1, 1'b0, 8'h10, 8'h00, "w0_rd10");
    xfer(1, 1'b0, 8'h11, 8'h00, "w0_rd11");

    // Out-of-range offset must not alias onto offset 0.
    xfer(0, 1'b1, 8'h00, 8'h5A, "oor_pre");
    xfer(0, 1'b1, 8'h80, 8'hFF, "oor_wr80");
    xfer(0, 1'b0, 8'h80, 8'h00, "oor_rd80");
    xfer(0, 1'b0, 8'h00, 8'h00, "oor_rd00");
    xfer(1, 1'b1, 8'hFF, 8'h77, "oor_b_wrff");

    // PSEL dropped in the second wait cycle.
    xfer(0, 1'b1, 8'h20, 8'h3C, "abort_pre");
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'hC3;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel_a = 1'b0;
    @(negedge pclk);
    ref_proto[0] = 1'b1;
    check("abort proto", 32'(proto_a), 32'd1);
    check("abort state", 32'(dut_a.state_q), 32'h1);
    check("abort ready", 32'(pready_a), 32'd0);
    check("abort b_proto", 32'(proto_b), 32'd0);
    penable = 1'b0;
    xfer(0, 1'b0, 8'h20, 8'h00, "abort_rd20");

    // Reset mid-transfer.
    xfer(0, 1'b1, 8'h30, 8'h01, "rst_pre");
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 8'h77;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); preset = 1'b1;
    @(negedge pclk);
    model_reset();
    check_idle_outputs("midrst");
    preset = 1'b0; psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk);
    xfer(0, 1'b0, 8'h30, 8'h00, "midrst_rd30");

    // Write data changes during the wait cycles: latched value is stored.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h50; pwdata = 8'h66;
    @(negedge pclk); penable = 1'b1; pwdata = 8'h77;
    repeat (2) @(negedge pclk);
    check("unstable ready", 32'(pready_a), 32'd1);
    @(negedge pclk);
    ref_proto[0] = 1'b1;
    ref_mem[0][8'h50] = 8'h66; ref_valid[0][8'h50] = 1'b1;
    check("unstable proto", 32'(proto_a), 32'd1);
    psel_a = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 8'h50, 8'h00, "unstable_rd50");
    do_reset("reset2");

    // Access phase straight out of IDLE.
    xfer(0, 1'b1, 8'h44, 8'h99, "idlev_pre");
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h44; pwdata = 8'h12;
    @(negedge pclk);
    check("idlev proto", 32'(proto_a), 32'd1);
    check("idlev ready1", 32'(pready_a), 32'd0);
    @(negedge pclk);
    check("idlev ready2", 32'(pready_a), 32'd0);
    ref_proto[0] = 1'b1;
    psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk);
    xfer(0, 1'b0, 8'h44, 8'h00, "idlev_rd44");

    // Randomized traffic against the model.
    for (int k = 0; k < 60; k++) begin
      w  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      xfer(w, wr, a, d, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) @(negedge pclk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
